loadunit_mq: RTL and testbench



---
 rtl/loadunit_mq.sv | 233 +++++++++++++++++++++++
 tb/tb_loadunit_mq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/loadunit_mq.sv
// Multi-outstanding load unit: DEPTH-entry table, tagged out-of-order bus reads, aligned writeback.
// Accept->req >=1 cycle, resp->wb 1 cycle; req/wb held stable (locked entry) while their ready is low.
module loadunit_mq #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = $clog2(DEPTH),
  parameter int PREG_W  = 7,
  parameter int ROB_LOG = 6,
  parameter int XLEN    = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PREG_W-1:0]  in_prd,
  input  logic               in_is_unsigned,
  input  logic [3:0]         in_ls_size,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_robidx_flag,
  input  logic [ROB_LOG-1:0] in_robidx,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [XLEN-1:0]    req_addr,
  output logic [TAG_W-1:0]   req_tag,
  input  logic               resp_valid,
  input  logic [TAG_W-1:0]   resp_tag,
  input  logic [XLEN-1:0]    resp_data,
  input  logic               flush_valid,
  input  logic               flush_robidx_flag,
  input  logic [ROB_LOG-1:0] flush_robidx,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [PREG_W-1:0]  wb_prd,
  output logic               wb_robidx_flag,
  output logic [ROB_LOG-1:0] wb_robidx,
  output logic [XLEN-1:0]    wb_data
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_INFL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state_q  [DEPTH];
  logic [1:0]         state_d  [DEPTH];
  logic [PREG_W-1:0]  prd_q    [DEPTH];
  logic               flag_q   [DEPTH];
  logic [ROB_LOG-1:0] rob_q    [DEPTH];
  logic [XLEN-1:0]    addr_q   [DEPTH];
  logic [3:0]         size_q   [DEPTH];
  logic               uns_q    [DEPTH];
  logic [XLEN-1:0]    data_q   [DEPTH];
  logic               killed_q [DEPTH];

  logic [DEPTH-1:0]   kill;
  logic               in_kill;
  logic               free_any;
  logic [TAG_W-1:0]   alloc_idx;
  logic               alloc_fire;
  logic               req_any;
  logic [TAG_W-1:0]   req_idx;
  logic               req_fire;
  logic               req_lock_vld;
  logic [TAG_W-1:0]   req_lock_idx;
  logic               wb_any;
  logic [TAG_W-1:0]   wb_idx;
  logic               wb_fire;
  logic               wb_lock_vld;
  logic [TAG_W-1:0]   wb_lock_idx;
  logic [XLEN-1:0]    resp_line;

  // Flag XOR makes the comparison correct across a ROB wrap.
  function automatic logic is_younger(input logic f_flag, input logic [ROB_LOG-1:0] f_idx,
                                      input logic e_flag, input logic [ROB_LOG-1:0] e_idx);
    return (f_flag ^ e_flag) ^ (f_idx < e_idx);
  endfunction

  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] line, input logic [2:0] off,
                                                 input logic [3:0] size, input logic uns);
    logic [XLEN-1:0] res;
    res = line;
    case (size)
      4'b0001: res = {{(XLEN-8){~uns & line[{off, 3'b000} + 7]}}, line[{off, 3'b000} +: 8]};
      4'b0010: res = {{(XLEN-16){~uns & line[{off[2:1], 4'b0000} + 15]}}, line[{off[2:1], 4'b0000} +: 16]};
      4'b0100: res = {{(XLEN-32){~uns & line[{off[2], 5'b00000} + 31]}}, line[{off[2], 5'b00000} +: 32]};
      default: res = line;
    endcase
    return res;
  endfunction

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++)
      kill[i] = flush_valid & is_younger(flush_robidx_flag, flush_robidx, flag_q[i], rob_q[i]);
  end

  assign in_kill = flush_valid & is_younger(flush_robidx_flag, flush_robidx, in_robidx_flag, in_robidx);

  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        free_any  = 1'b1;
        alloc_idx = TAG_W'(i);
      end
    end
  end

  assign alloc_fire = in_valid & free_any & ~in_kill;

  // A stalled request/writeback keeps its entry even if a lower index becomes eligible.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_WAIT && !kill[i]) begin
        req_any = 1'b1;
        req_idx = TAG_W'(i);
      end
    end
    if (req_lock_vld && state_q[req_lock_idx] == ST_WAIT && !kill[req_lock_idx]) begin
      req_any = 1'b1;
      req_idx = req_lock_idx;
    end
  end

  always_comb begin
    wb_any = 1'b0;
    wb_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_DONE && !kill[i]) begin
        wb_any = 1'b1;
        wb_idx = TAG_W'(i);
      end
    end
    if (wb_lock_vld && state_q[wb_lock_idx] == ST_DONE && !kill[wb_lock_idx]) begin
      wb_any = 1'b1;
      wb_idx = wb_lock_idx;
    end
  end

  assign req_fire  = req_any & req_ready;
  assign wb_fire   = wb_any & wb_ready;
  assign resp_line = align_load(resp_data, addr_q[resp_tag][2:0], size_q[resp_tag], uns_q[resp_tag]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_FREE: if (alloc_fire && alloc_idx == TAG_W'(i)) state_d[i] = ST_WAIT;
        ST_WAIT: begin
          if (kill[i])                                  state_d[i] = ST_FREE;
          else if (req_fire && req_idx == TAG_W'(i))    state_d[i] = ST_INFL;
        end
        // A killed in-flight entry must wait for its response so the tag is not reused early.
        ST_INFL: begin
          if (resp_valid && resp_tag == TAG_W'(i))
            state_d[i] = (killed_q[i] || kill[i]) ? ST_FREE : ST_DONE;
        end
        ST_DONE: begin
          if (kill[i])                                  state_d[i] = ST_FREE;
          else if (wb_fire && wb_idx == TAG_W'(i))      state_d[i] = ST_FREE;
        end
        default: state_d[i] = ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        prd_q[i]    <= '0;
        flag_q[i]   <= 1'b0;
        rob_q[i]    <= '0;
        addr_q[i]   <= '0;
        size_q[i]   <= '0;
        uns_q[i]    <= 1'b0;
        data_q[i]   <= '0;
        killed_q[i] <= 1'b0;
      end
      req_lock_vld <= 1'b0;
      req_lock_idx <= '0;
      wb_lock_vld  <= 1'b0;
      wb_lock_idx  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_q[i] == ST_FREE && alloc_fire && alloc_idx == TAG_W'(i)) begin
          prd_q[i]    <= in_prd;
          flag_q[i]   <= in_robidx_flag;
          rob_q[i]    <= in_robidx;
          addr_q[i]   <= in_src1 + in_imm;
          size_q[i]   <= in_ls_size;
          uns_q[i]    <= in_is_unsigned;
          killed_q[i] <= 1'b0;
        end
        if (state_q[i] == ST_INFL) begin
          if (resp_valid && resp_tag == TAG_W'(i)) begin
            killed_q[i] <= 1'b0;
            if (!(killed_q[i] || kill[i])) data_q[i] <= resp_line;
          end else if (kill[i]) begin
            killed_q[i] <= 1'b1;
          end
        end
      end
      req_lock_vld <= req_any & ~req_ready;
      req_lock_idx <= req_idx;
      wb_lock_vld  <= wb_any & ~wb_ready;
      wb_lock_idx  <= wb_idx;
    end
  end

  always_comb begin
    in_ready       = free_any;
    req_valid      = req_any;
    req_addr       = req_any ? {addr_q[req_idx][XLEN-1:3], 3'b000} : '0;
    req_tag        = req_any ? req_idx : '0;
    wb_valid       = wb_any;
    wb_prd         = wb_any ? prd_q[wb_idx] : '0;
    wb_robidx_flag = wb_any ? flag_q[wb_idx] : 1'b0;
    wb_robidx      = wb_any ? rob_q[wb_idx] : '0;
    wb_data        = wb_any ? data_q[wb_idx] : '0;
  end

endmodule

// File: tb/tb_loadunit_mq.sv
// Scoreboarded bench for loadunit_mq: expected writebacks queued at response time, checked on wb fire.
module tb_loadunit_mq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_is_unsigned, in_robidx_flag;
  logic [6:0]  in_prd;
  logic [3:0]  in_ls_size;
  logic [63:0] in_src1, in_imm;
  logic [5:0]  in_robidx;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_tag;
  logic        resp_valid;
  logic [1:0]  resp_tag;
  logic [63:0] resp_data;
  logic        flush_valid, flush_robidx_flag;
  logic [5:0]  flush_robidx;
  logic        wb_valid, wb_ready, wb_robidx_flag;
  logic [6:0]  wb_prd;
  logic [5:0]  wb_robidx;
  logic [63:0] wb_data;

  always #5 clock = ~clock;

  loadunit_mq dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prd(in_prd), .in_is_unsigned(in_is_unsigned),
    .in_ls_size(in_ls_size), .in_src1(in_src1), .in_imm(in_imm),
    .in_robidx_flag(in_robidx_flag), .in_robidx(in_robidx),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_prd(wb_prd),
    .wb_robidx_flag(wb_robidx_flag), .wb_robidx(wb_robidx), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [6:0]  prd;
    logic        flag;
    logic [5:0]  rob;
    logic [63:0] data;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t mon_e;
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [6:0] prd, input logic uns, input logic [3:0] size,
                      input logic [63:0] src1, input logic [63:0] imm,
                      input logic flag, input logic [5:0] rob);
    check("in_ready_before_load", in_ready, 1);
    in_valid = 1'b1; in_prd = prd; in_is_unsigned = uns; in_ls_size = size;
    in_src1 = src1; in_imm = imm; in_robidx_flag = flag; in_robidx = rob;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [6:0] prd, input logic flag, input logic [5:0] rob,
                          input logic [63:0] data);
    sb.push_back({prd, flag, rob, data});
  endtask

  task automatic respond(input logic [1:0] tag, input logic [63:0] data);
    resp_valid = 1'b1; resp_tag = tag; resp_data = data;
    tick();
    resp_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_data", wb_data, mon_e.data);
        check("wb_meta", {wb_prd, wb_robidx_flag, wb_robidx}, {mon_e.prd, mon_e.flag, mon_e.rob});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  localparam logic [63:0] SWEEP = 64'h8000_8000_8000_8080;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_prd = '0; in_is_unsigned = 1'b0; in_ls_size = '0;
    in_src1 = '0; in_imm = '0; in_robidx_flag = 1'b0; in_robidx = '0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_tag = '0; resp_data = '0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0; wb_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("rst_in_ready", in_ready, 1);
    check("rst_req_valid", req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_wb_data", wb_data, 0);

    // Single signed byte load at 0x1005
    in_valid = 1'b1; in_prd = 7'd5; in_is_unsigned = 1'b0; in_ls_size = 4'b0001;
    in_src1 = 64'h1000; in_imm = 64'h5; in_robidx_flag = 1'b0; in_robidx = 6'd1;
    #1;
    check("no_bypass_req", req_valid, 0);
    tick();
    in_valid = 1'b0;
    check("t1_req_valid", req_valid, 1);
    check("t1_req_addr", req_addr, 64'h1000);
    check("t1_req_tag", req_tag, 0);
    tick();
    check("t1_req_done", req_valid, 0);
    push_exp(7'd5, 1'b0, 6'd1, 64'hFFFF_FFFF_FFFF_FF80);
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = 64'h0000_8000_0000_0000;
    #1;
    check("t1_wb_not_early", wb_valid, 0);
    tick();
    resp_valid = 1'b0;
    check("t1_wb_at_r1", wb_valid, 1);
    tick();

    // Fill all four entries, answer out of order
    for (int i = 0; i < 4; i++)
      load(7'(10 + i), 1'b0, 4'b1000, 64'h2000 + 64'(8 * i), 64'h0, 1'b0, 6'(i + 1));
    check("full_in_ready", in_ready, 0);
    repeat (2) tick();
    push_exp(7'd13, 1'b0, 6'd4, 64'hA5A5_0000_0000_0003);
    respond(2'd3, 64'hA5A5_0000_0000_0003);
    check("in_ready_wb_cycle", in_ready, 0);
    push_exp(7'd11, 1'b0, 6'd2, 64'hA5A5_0000_0000_0001);
    respond(2'd1, 64'hA5A5_0000_0000_0001);
    check("in_ready_after_wb", in_ready, 1);
    push_exp(7'd10, 1'b0, 6'd1, 64'hA5A5_0000_0000_0000);
    respond(2'd0, 64'hA5A5_0000_0000_0000);
    push_exp(7'd12, 1'b0, 6'd3, 64'hA5A5_0000_0000_0002);
    respond(2'd2, 64'hA5A5_0000_0000_0002);
    repeat (2) tick();

    // Request and writeback backpressure; unsigned word at offset 4
    req_ready = 1'b0;
    load(7'd20, 1'b1, 4'b0100, 64'h3000, 64'h4, 1'b0, 6'd5);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_valid", req_valid, 1);
      check("bp_req_addr", req_addr, 64'h3000);
      check("bp_req_tag", req_tag, 0);
      tick();
    end
    req_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    push_exp(7'd20, 1'b0, 6'd5, 64'h0000_0000_8000_8000);
    respond(2'd0, SWEEP);
    for (int i = 0; i < 4; i++) begin
      check("bp_wb_valid", wb_valid, 1);
      check("bp_wb_data", wb_data, 64'h0000_0000_8000_8000);
      check("bp_wb_robidx", wb_robidx, 5);
      tick();
    end
    wb_ready = 1'b1;
    tick();

    // Flush at robidx 2: rob1 DONE survives, rob3 WAIT and rob4 INFLIGHT die
    wb_ready = 1'b0;
    load(7'd30, 1'b0, 4'b1000, 64'h5000, 64'h0, 1'b0, 6'd1);
    tick();
    push_exp(7'd30, 1'b0, 6'd1, 64'h1234_5678_9ABC_DEF0);
    respond(2'd0, 64'h1234_5678_9ABC_DEF0);
    load(7'd31, 1'b0, 4'b1000, 64'h5100, 64'h0, 1'b0, 6'd4);
    tick();
    req_ready = 1'b0;
    load(7'd32, 1'b0, 4'b1000, 64'h5200, 64'h0, 1'b0, 6'd3);
    check("fl_req_before", req_valid, 1);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 6'd2;
    #1;
    check("fl_masks_req", req_valid, 0);
    check("fl_older_wb_valid", wb_valid, 1);
    tick();
    flush_valid = 1'b0;
    check("fl_wait_freed", req_valid, 0);
    req_ready = 1'b1;
    respond(2'd1, 64'hDEAD_BEEF_DEAD_BEEF);
    check("fl_older_still_done", wb_valid, 1);
    check("fl_older_robidx", wb_robidx, 1);
    wb_ready = 1'b1;
    tick();
    check("fl_killed_no_wb", wb_valid, 0);
    tick();

    // ROB wrap kill, then the extension sweep on survivors
    req_ready = 1'b0;
    load(7'd40, 1'b0, 4'b0001, 64'h4000, 64'h0, 1'b1, 6'd0);
    load(7'd41, 1'b1, 4'b0001, 64'h4000, 64'h0, 1'b0, 6'd62);
    load(7'd42, 1'b0, 4'b0010, 64'h4000, 64'h2, 1'b0, 6'd61);
    load(7'd43, 1'b0, 4'b1000, 64'h4008, 64'h0, 1'b0, 6'd60);
    check("wrap_full", in_ready, 0);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 6'd63;
    #1;
    check("wrap_req_valid", req_valid, 1);
    check("wrap_req_tag_masked", req_tag, 1);
    tick();
    flush_valid = 1'b0;
    check("wrap_killed_freed", in_ready, 1);
    check("wrap_survivor_req", req_tag, 1);
    req_ready = 1'b1;
    repeat (3) tick();
    check("wrap_all_issued", req_valid, 0);
    push_exp(7'd41, 1'b0, 6'd62, 64'h0000_0000_0000_0080);
    respond(2'd1, SWEEP);
    push_exp(7'd42, 1'b0, 6'd61, 64'hFFFF_FFFF_FFFF_8000);
    respond(2'd2, SWEEP);
    push_exp(7'd43, 1'b0, 6'd60, SWEEP);
    respond(2'd3, SWEEP);
    repeat (3) tick();

    check("sb_empty", sb.size(), 0);
    check("end_in_ready", in_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
